alu_stream: RTL and testbench

- Byte-stream ALU: accepts framed command packets on a valid/ready byte input and returns status plus result bytes on a valid/ready byte output.
- Sits between the UART RX and UART TX stream endpoints. It is the functional successor to the plain UART loopback.
- Operand width is parametrised in bytes.
- Adds an inter-byte timeout so a broken host link resynchronises.

---
 rtl/alu_stream.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_stream.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_stream.sv
// alu_stream: byte-stream ALU. Receives opcode + two little-endian operands
// over a valid/ready byte input, returns a status byte followed by the
// result bytes (LSB first) over a valid/ready byte output. An optional
// inter-byte timeout drops half-received packets so the host can resync.
module alu_stream #(
  parameter int DATA_WIDTH     = 8,
  parameter int OPERAND_BYTES  = 4,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i
);

  localparam int W       = OPERAND_BYTES * DATA_WIDTH;
  localparam int CW      = (OPERAND_BYTES > 1) ? $clog2(OPERAND_BYTES) : 1;
  localparam int TO_LAST = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int IW      = (TO_LAST > 0) ? $clog2(TO_LAST + 1) : 1;

  localparam logic [CW-1:0]         CNT_LAST   = CW'(OPERAND_BYTES - 1);
  localparam logic [IW-1:0]         IDLE_LAST  = IW'(TO_LAST);
  localparam logic [DATA_WIDTH-1:0] ST_BADOP   = DATA_WIDTH'(8'hFF);
  localparam logic [DATA_WIDTH-1:0] ST_TIMEOUT = DATA_WIDTH'(8'hFE);
  localparam logic [DATA_WIDTH-1:0] OP_MAX     = DATA_WIDTH'(8'h05);

  typedef enum logic [2:0] {
    S_OPCODE,
    S_RX_A,
    S_RX_B,
    S_EXEC,
    S_TX_STATUS,
    S_TX_RES
  } state_t;

  state_t                state_q;
  logic [2:0]            opcode_q;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [W-1:0]          result_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;
  logic [IW-1:0]         idle_q;
  logic                  ready_q;
  logic                  valid_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic [W-1:0]          result_d;
  logic                  carry_d;
  logic [DATA_WIDTH-1:0] status_d;
  logic [W:0]            sum_w;
  logic [W:0]            diff_w;
  logic [2*W-1:0]        prod_w;

  logic accept;
  logic xfer;
  logic timeout_hit;

  assign accept      = valid_i & ready_q;
  assign xfer        = valid_q & ready_i;
  // Idle counter only matters when a timeout is configured.
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (idle_q == IDLE_LAST);

  assign ready_o = ready_q;
  assign valid_o = valid_q;
  assign data_o  = data_q;

  // Combinational ALU on the latched operands; sampled only in EXEC.
  always_comb begin
    sum_w    = {1'b0, a_q} + {1'b0, b_q};
    diff_w   = {1'b0, a_q} - {1'b0, b_q};
    prod_w   = {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q};
    result_d = '0;
    carry_d  = 1'b0;
    case (opcode_q)
      3'd0: begin
        result_d = sum_w[W-1:0];
        carry_d  = sum_w[W];
      end
      3'd1: begin
        result_d = diff_w[W-1:0];
        carry_d  = diff_w[W];          // borrow out == unsigned A < B
      end
      3'd2: result_d = a_q & b_q;
      3'd3: result_d = a_q | b_q;
      3'd4: result_d = a_q ^ b_q;
      3'd5: begin
        result_d = prod_w[W-1:0];
        carry_d  = |prod_w[2*W-1:W];   // product overflowed the result width
      end
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
    status_d    = '0;
    status_d[0] = carry_d;
    status_d[1] = (result_d == '0);
  end

  // Packet FSM with registered handshake and data outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_OPCODE;
      opcode_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      idle_q   <= '0;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      case (state_q)
        S_OPCODE: begin
          // Also raises ready on the first edge after reset release.
          ready_q <= 1'b1;
          if (accept) begin
            if (data_i <= OP_MAX) begin
              opcode_q <= data_i[2:0];
              cnt_q    <= '0;
              idle_q   <= '0;
              state_q  <= S_RX_A;
            end else begin
              // Unknown opcode: answer with error status only, consume nothing more.
              ready_q <= 1'b0;
              valid_q <= 1'b1;
              data_q  <= ST_BADOP;
              err_q   <= 1'b1;
              state_q <= S_TX_STATUS;
            end
          end
        end

        S_RX_A, S_RX_B: begin
          if (accept) begin
            idle_q <= '0;
            if (state_q == S_RX_A) begin
              a_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= data_i;
            end else begin
              b_q[cnt_q*DATA_WIDTH +: DATA_WIDTH] <= data_i;
            end
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (state_q == S_RX_A) begin
                state_q <= S_RX_B;
              end else begin
                ready_q <= 1'b0;
                state_q <= S_EXEC;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (timeout_hit) begin
            // Host went quiet mid-packet: abandon it and report.
            cnt_q   <= '0;
            idle_q  <= '0;
            ready_q <= 1'b0;
            valid_q <= 1'b1;
            data_q  <= ST_TIMEOUT;
            err_q   <= 1'b1;
            state_q <= S_TX_STATUS;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
        end

        S_EXEC: begin
          result_q <= result_d;
          data_q   <= status_d;
          valid_q  <= 1'b1;
          err_q    <= 1'b0;
          state_q  <= S_TX_STATUS;
        end

        S_TX_STATUS: begin
          if (xfer) begin
            if (err_q) begin
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              state_q <= S_OPCODE;
            end else begin
              // Result leaves LSB first by shifting the register down a byte per transfer.
              data_q   <= result_q[DATA_WIDTH-1:0];
              result_q <= result_q >> DATA_WIDTH;
              cnt_q    <= '0;
              state_q  <= S_TX_RES;
            end
          end
        end

        S_TX_RES: begin
          if (xfer) begin
            if (cnt_q == CNT_LAST) begin
              valid_q <= 1'b0;
              ready_q <= 1'b1;
              cnt_q   <= '0;
              state_q <= S_OPCODE;
            end else begin
              data_q   <= result_q[DATA_WIDTH-1:0];
              result_q <= result_q >> DATA_WIDTH;
              cnt_q    <= cnt_q + 1'b1;
            end
          end
        end

        default: begin
          ready_q <= 1'b0;
          valid_q <= 1'b0;
          state_q <= S_OPCODE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: scoreboard bench for alu_stream. Main instance uses
// 2-byte operands with a 16-cycle timeout; a second instance uses 4-byte
// operands for the wide multiply case.
module tb_alu_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] data_i  = 8'h00;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i = 1'b1;

  logic [7:0] d4_data_i  = 8'h00;
  logic       d4_valid_i = 1'b0;
  logic       d4_ready_o;
  logic [7:0] d4_data_o;
  logic       d4_valid_o;
  logic       d4_ready_i = 1'b1;

  int checks = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];

  always #5 clk = ~clk;

  alu_stream #(.DATA_WIDTH(8), .OPERAND_BYTES(2), .TIMEOUT_CYCLES(16)) u_dut (
    .clk_i(clk), .rst_i(rst),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i)
  );

  alu_stream #(.DATA_WIDTH(8), .OPERAND_BYTES(4), .TIMEOUT_CYCLES(0)) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .data_i(d4_data_i), .valid_i(d4_valid_i), .ready_o(d4_ready_o),
    .data_o(d4_data_o), .valid_o(d4_valid_o), .ready_i(d4_ready_i)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model for 16-bit operands: pushes the expected response bytes.
  function automatic void push_exp(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] wide;
    logic [15:0] r;
    logic        c;
    r = 16'h0000;
    c = 1'b0;
    case (op)
      8'h00: begin wide = 32'(a) + 32'(b); r = wide[15:0]; c = (wide > 32'h0000FFFF); end
      8'h01: begin r = a - b; c = (a < b); end
      8'h02: r = a & b;
      8'h03: r = a | b;
      8'h04: r = a ^ b;
      8'h05: begin wide = 32'(a) * 32'(b); r = wide[15:0]; c = (wide > 32'h0000FFFF); end
      default: begin
        exp_q.push_back(8'hFF);
        return;
      end
    endcase
    exp_q.push_back({6'd0, (r == 16'h0000), c});
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
  endfunction

  // Drive one byte and return once it has been accepted (bounded wait).
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    data_i  = b;
    valid_i = 1'b1;
    while (ready_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (ready_o !== 1'b1) begin
      fails++;
      $display("FAIL send_byte: ready_o=%b after %0d cycles, required 1", ready_o, n);
      valid_i = 1'b0;
      return;
    end
    tick();
    valid_i = 1'b0;
  endtask

  task automatic send_packet(input logic [7:0] op, input logic [15:0] a, input logic [15:0] b);
    $display("pkt op=%h a=%h b=%h", op, a, b);
    send_byte(op);
    if (op <= 8'h05) begin
      send_byte(a[7:0]);
      send_byte(a[15:8]);
      send_byte(b[7:0]);
      send_byte(b[15:8]);
    end
  endtask

  // Wait for an outbound byte, capture it and ready_o, and complete the transfer.
  task automatic take_byte(output logic [7:0] got, output logic ro);
    int n;
    n = 0;
    ready_i = 1'b1;
    while (valid_o !== 1'b1 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (valid_o !== 1'b1) begin
      fails++;
      $display("FAIL take_byte: valid_o=%b after %0d cycles, required 1", valid_o, n);
      got = 8'hxx;
      ro  = 1'bx;
      return;
    end
    got = data_o;
    ro  = ready_o;
    tick();
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b, expected 0", ready_o); end
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", valid_o); end
    checks++;
    if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h, expected 00", data_o); end
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL release_ready_early: got %b, expected 0", ready_o); end
    tick();
    checks++;
    if (ready_o !== 1'b1) begin fails++; $display("FAIL release_ready: got %b, expected 1", ready_o); end
    checks++;
    if (d4_ready_o !== 1'b1) begin fails++; $display("FAIL release_ready4: got %b, expected 1", d4_ready_o); end
  endtask

  // ADD with exact cycle timing: one-cycle EXEC, then bubble-free transmission.
  task automatic test_add_timing();
    logic [7:0] e;
    ready_i = 1'b1;
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h35);
    exp_q.push_back(8'h12);
    send_packet(8'h00, 16'h1234, 16'h0001);
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL add_exec_valid: got %b, expected 0", valid_o); end
    checks++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL add_exec_ready: got %b, expected 0", ready_o); end
    tick();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (valid_o !== 1'b1) begin fails++; $display("FAIL add_b2b_valid: got %b, expected 1", valid_o); end
      checks++;
      if (data_o !== e) begin fails++; $display("FAIL add_byte: got %h, expected %h", data_o, e); end
      tick();
    end
    checks++;
    if (valid_o !== 1'b0) begin fails++; $display("FAIL add_end_valid: got %b, expected 0", valid_o); end
    checks++;
    if (ready_o !== 1'b1) begin fails++; $display("FAIL add_end_ready: got %b, expected 1", ready_o); end
  endtask

  // Fixed vectors: ADD wrap, SUB borrow, MUL overflow.
  task automatic test_vectors();
    logic [7:0]  v_op[3]  = '{8'h00, 8'h01, 8'h05};
    logic [15:0] v_a[3]   = '{16'hFFFF, 16'h0001, 16'h0100};
    logic [15:0] v_b[3]   = '{16'h0001, 16'h0002, 16'h0100};
    logic [23:0] v_exp[3] = '{24'h03_00_00, 24'h01_FF_FF, 24'h03_00_00};
    logic [7:0]  got;
    logic [7:0]  e;
    logic        ro;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(v_exp[i][23:16]);
      exp_q.push_back(v_exp[i][15:8]);
      exp_q.push_back(v_exp[i][7:0]);
      send_packet(v_op[i], v_a[i], v_b[i]);
      while (exp_q.size() > 0) begin
        take_byte(got, ro);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin fails++; $display("FAIL vector%0d_byte: got %h, expected %h", i, got, e); end
        checks++;
        if (ro !== 1'b0) begin fails++; $display("FAIL vector%0d_ready: ready_o=%b during response, expected 0", i, ro); end
      end
    end
  endtask

  // Four-byte operand instance: 3 * 7.
  task automatic test_mul_wide();
    logic [7:0] pkt[9] = '{8'h05, 8'h03, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
    logic [7:0] e;
    int n;
    $display("pkt4 op=05 a=00000003 b=00000007");
    exp4_q.push_back(8'h00);
    exp4_q.push_back(8'h15);
    exp4_q.push_back(8'h00);
    exp4_q.push_back(8'h00);
    exp4_q.push_back(8'h00);
    d4_ready_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      d4_data_i  = pkt[i];
      d4_valid_i = 1'b1;
      n = 0;
      while (d4_ready_o !== 1'b1 && n < 100) begin tick(); n++; end
      checks++;
      if (d4_ready_o !== 1'b1) begin fails++; $display("FAIL mul4_accept%0d: ready_o=%b, expected 1", i, d4_ready_o); end
      tick();
      d4_valid_i = 1'b0;
    end
    while (exp4_q.size() > 0) begin
      n = 0;
      while (d4_valid_o !== 1'b1 && n < 100) begin tick(); n++; end
      e = exp4_q.pop_front();
      checks++;
      if (d4_valid_o !== 1'b1 || d4_data_o !== e) begin
        fails++;
        $display("FAIL mul4_byte: got %h (valid %b), expected %h", d4_data_o, d4_valid_o, e);
      end
      tick();
    end
    checks++;
    if (d4_valid_o !== 1'b0) begin fails++; $display("FAIL mul4_end_valid: got %b, expected 0", d4_valid_o); end
  endtask

  task automatic test_bad_opcode_backpressure();
    logic [7:0] got;
    logic [7:0] e;
    logic       ro;
    ready_i = 1'b1;
    $display("pkt op=07 (no operands)");
    exp_q.push_back(8'hFF);
    send_byte(8'h07);
    take_byte(got, ro);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin fails++; $display("FAIL badop_status: got %h, expected %h", got, e); end
    checks++;
    if (ro !== 1'b0) begin fails++; $display("FAIL badop_ready: got %b, expected 0", ro); end
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL badop_done: valid_o=%b ready_o=%b, expected 0/1", valid_o, ready_o);
    end
    push_exp(8'h02, 16'h000F, 16'h00F0);
    send_packet(8'h02, 16'h000F, 16'h00F0);
    take_byte(got, ro);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin fails++; $display("FAIL and_status: got %h, expected %h", got, e); end
    // Stall the first result byte for five cycles.
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid_o !== 1'b1 || data_o !== exp_q[0] || ready_o !== 1'b0) begin
        fails++;
        $display("FAIL stall%0d: valid_o=%b data_o=%h ready_o=%b, expected 1/%h/0", i, valid_o, data_o, ready_o, exp_q[0]);
      end
    end
    while (exp_q.size() > 0) begin
      take_byte(got, ro);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin fails++; $display("FAIL and_byte: got %h, expected %h", got, e); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  got;
    logic [7:0]  e;
    logic        ro;
    for (int i = 0; i < 10; i++) begin
      op = 8'($urandom_range(0, 7));
      a  = 16'($urandom);
      b  = 16'($urandom);
      if (i == 0) begin op = 8'h00; a = 16'hFFFF; b = 16'hFFFF; end
      if (i == 1) begin op = 8'h01; a = 16'h8000; b = 16'h8000; end
      push_exp(op, a, b);
      send_packet(op, a, b);
      while (exp_q.size() > 0) begin
        take_byte(got, ro);
        e = exp_q.pop_front();
        checks++;
        if (got !== e) begin fails++; $display("FAIL rand%0d_op%h: got %h, expected %h", i, op, got, e); end
        checks++;
        if (ro !== 1'b0) begin fails++; $display("FAIL rand%0d_ready: got %b, expected 0", i, ro); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0] got;
    logic [7:0] e;
    logic       ro;
    ready_i = 1'b1;
    $display("pkt op=00 a=..34 then idle");
    exp_q.push_back(8'hFE);
    send_byte(8'h00);
    send_byte(8'h34);
    repeat (15) tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_early: valid_o=%b ready_o=%b after 15 idle, expected 0/1", valid_o, ready_o);
    end
    tick();
    e = exp_q.pop_front();
    checks++;
    if (valid_o !== 1'b1 || data_o !== e) begin
      fails++;
      $display("FAIL timeout_status: valid_o=%b data_o=%h, expected 1/%h", valid_o, data_o, e);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      fails++;
      $display("FAIL timeout_done: valid_o=%b ready_o=%b, expected 0/1", valid_o, ready_o);
    end
    push_exp(8'h00, 16'h0001, 16'h0001);
    send_packet(8'h00, 16'h0001, 16'h0001);
    while (exp_q.size() > 0) begin
      take_byte(got, ro);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin fails++; $display("FAIL after_timeout_byte: got %h, expected %h", got, e); end
    end
  endtask

  task automatic test_reset_mid_response();
    logic [7:0] got;
    logic [7:0] e;
    logic       ro;
    push_exp(8'h04, 16'hA5A5, 16'h0FF0);
    send_packet(8'h04, 16'hA5A5, 16'h0FF0);
    take_byte(got, ro);
    e = exp_q.pop_front();
    checks++;
    if (got !== e) begin fails++; $display("FAIL xor_status: got %h, expected %h", got, e); end
    ready_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b0 || data_o !== 8'h00) begin
      fails++;
      $display("FAIL midreset: valid_o=%b ready_o=%b data_o=%h, expected 0/0/00", valid_o, ready_o, data_o);
    end
    exp_q.delete();
    tick();
    rst = 1'b0;
    checks++;
    if (ready_o !== 1'b0) begin fails++; $display("FAIL midreset_release_early: got %b, expected 0", ready_o); end
    tick();
    checks++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      fails++;
      $display("FAIL midreset_release: ready_o=%b valid_o=%b, expected 1/0", ready_o, valid_o);
    end
    ready_i = 1'b1;
    push_exp(8'h03, 16'h1200, 16'h0034);
    send_packet(8'h03, 16'h1200, 16'h0034);
    while (exp_q.size() > 0) begin
      take_byte(got, ro);
      e = exp_q.pop_front();
      checks++;
      if (got !== e) begin fails++; $display("FAIL after_reset_byte: got %h, expected %h", got, e); end
    end
  endtask

  initial begin
    test_reset();
    test_add_timing();
    test_vectors();
    test_mul_wide();
    test_bad_opcode_backpressure();
    test_random();
    test_timeout();
    test_reset_mid_response();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
